// File: rtl/smvm_result_collector_if.sv
// Result-collector bus: SMVM result stream in, tagged words out, job status.
interface smvm_result_collector_if #(
  parameter int DATA_W = 14,
  parameter int ROW_W  = 8,
  parameter int DEPTH  = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              start;
  logic [ROW_W-1:0]  rows_in;
  logic              in_valid;
  logic [DATA_W-1:0] data_in;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ROW_W-1:0]  out_row;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [LVL_W-1:0]  level;

  // Master is the environment: it issues jobs, feeds results, consumes words.
  modport master (
    output start, rows_in, in_valid, data_in, out_ready,
    input  out_valid, out_data, out_row, busy, done, overflow, level
  );

  // Slave is the collector itself.
  modport slave (
    input  start, rows_in, in_valid, data_in, out_ready,
    output out_valid, out_data, out_row, busy, done, overflow, level
  );
endinterface

// File: rtl/smvm_result_collector.sv
// Captures the unthrottled SMVM result burst into a small FIFO, tags each
// word with its row index and drains it over a valid/ready handshake.
// done pulses once every expected row has been received and drained.
module smvm_result_collector #(
  parameter int DATA_W = 14,
  parameter int ROW_W  = 8,
  parameter int DEPTH  = 8
) (
  input logic clk,
  input logic rst,
  smvm_result_collector_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FLUSH
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ROW_W-1:0]  mem_row  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [ROW_W-1:0]  rows;
  logic [ROW_W-1:0]  rx;
  logic [ROW_W-1:0]  tx;
  logic              overflow;
  logic              done;

  logic full;
  logic empty;
  logic accept;
  logic do_rd;
  logic do_wr;
  logic last_row;

  // A word is only dropped when full and nothing leaves in the same cycle.
  always_comb begin
    full     = (level == LVL_W'(DEPTH));
    empty    = (level == '0);
    accept   = (state == COLLECT) && bus.in_valid;
    do_rd    = !empty && bus.out_ready;
    do_wr    = accept && (!full || do_rd);
    last_row = accept && (rx == rows - ROW_W'(1));
  end

  // FIFO storage, pointers, occupancy and the job FSM with its status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rows     <= '0;
      rx       <= '0;
      tx       <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_row[i]  <= '0;
      end
    end else begin
      done <= 1'b0;

      if (do_wr) begin
        mem_data[wr_ptr] <= bus.data_in;
        mem_row[wr_ptr]  <= rx;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end

      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        tx     <= tx + ROW_W'(1);
      end

      case ({do_wr, do_rd})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      case (state)
        IDLE: begin
          if (bus.start) begin
            rows     <= bus.rows_in;
            rx       <= '0;
            tx       <= '0;
            overflow <= 1'b0;
            if (bus.rows_in != '0) begin
              state <= COLLECT;
            end else begin
              done <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            rx <= rx + ROW_W'(1);
            if (!do_wr) begin
              overflow <= 1'b1;
            end
            if (last_row) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (empty) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = mem_data[rd_ptr];
  assign bus.out_row   = mem_row[rd_ptr];
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
  assign bus.overflow  = overflow;
  assign bus.level     = level;
endmodule
